// File: rtl/dac_ctrl.sv
// Push-button driven 8-bit value register with a free-running DAC write sequencer.
// Define DAC_CTRL_SATURATE_EN to clamp the value at 0/255 instead of wrapping.
module dac_ctrl #(
  parameter int DELAY_CYCLES = 10,
  parameter int PULSE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn,
  input  logic       add_sel,
  output logic       dac_csn,
  output logic       dac_ldacn,
  output logic       dac_wrn,
  output logic       dac_a_b,
  output logic [7:0] dac_d,
  output logic [7:0] led_out
);

  typedef enum logic [1:0] {
    ST_DELAY   = 2'd0,
    ST_SET_WRN = 2'd1,
    ST_UP_DATA = 2'd2,
    ST_LOAD    = 2'd3
  } state_t;

  localparam logic [7:0] DLY_LAST = 8'(DELAY_CYCLES - 1);
  localparam logic [7:0] PLS_LAST = 8'(PULSE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] value_q, value_d;
  logic [5:0] btn_prev_q, btn_prev_d;
  logic       csn_q, csn_d;
  logic       wrn_q, wrn_d;
  logic       ldacn_q, ldacn_d;
  logic       a_b_q, a_b_d;
  logic [7:0] dac_d_q, dac_d_d;

  logic [5:0] evt;
  logic       step_vld;
  logic       step_up;
  logic [3:0] step_mag;

  // Rising-edge events; only the highest-index event is honoured per cycle.
  always_comb begin
    evt        = btn & ~btn_prev_q;
    btn_prev_d = btn;
    step_vld   = 1'b1;
    step_up    = 1'b0;
    step_mag   = 4'd0;
    if (evt[5]) begin
      step_up  = 1'b1;
      step_mag = 4'd1;
    end else if (evt[4]) begin
      step_mag = 4'd1;
    end else if (evt[3]) begin
      step_up  = 1'b1;
      step_mag = 4'd2;
    end else if (evt[2]) begin
      step_mag = 4'd2;
    end else if (evt[1]) begin
      step_up  = 1'b1;
      step_mag = 4'd8;
    end else if (evt[0]) begin
      step_mag = 4'd8;
    end else begin
      step_vld = 1'b0;
    end
  end

`ifdef DAC_CTRL_SATURATE_EN
  logic [8:0] sum_up;
  logic [8:0] sum_dn;

  always_comb begin
    sum_up  = {1'b0, value_q} + {5'b0, step_mag};
    sum_dn  = {1'b0, value_q} - {5'b0, step_mag};
    value_d = value_q;
    if (step_vld) begin
      if (step_up) begin
        value_d = sum_up[8] ? 8'hFF : sum_up[7:0];
      end else begin
        value_d = sum_dn[8] ? 8'h00 : sum_dn[7:0];
      end
    end
  end
`else
  always_comb begin
    value_d = value_q;
    if (step_vld) begin
      if (step_up) begin
        value_d = value_q + {4'b0, step_mag};
      end else begin
        value_d = value_q - {4'b0, step_mag};
      end
    end
  end
`endif

  // Write sequencer: DELAY -> SET_WRN -> UP_DATA -> LOAD -> DELAY, forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    a_b_d   = a_b_q;
    dac_d_d = dac_d_q;
    unique case (state_q)
      ST_DELAY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ST_SET_WRN;
          cnt_d   = 8'd0;
          dac_d_d = value_q;
          a_b_d   = add_sel;
        end
      end
      ST_SET_WRN: begin
        if (cnt_q == PLS_LAST) begin
          state_d = ST_UP_DATA;
          cnt_d   = 8'd0;
        end
      end
      ST_UP_DATA: begin
        state_d = ST_LOAD;
        cnt_d   = 8'd0;
      end
      ST_LOAD: begin
        if (cnt_q == PLS_LAST) begin
          state_d = ST_DELAY;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_DELAY;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_comb begin
    csn_d   = 1'b1;
    wrn_d   = 1'b1;
    ldacn_d = 1'b1;
    unique case (state_d)
      ST_SET_WRN: begin
        csn_d = 1'b0;
        wrn_d = 1'b0;
      end
      ST_UP_DATA: csn_d   = 1'b0;
      ST_LOAD:    ldacn_d = 1'b0;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DELAY;
      cnt_q      <= 8'd0;
      value_q    <= 8'd0;
      btn_prev_q <= 6'd0;
      csn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      ldacn_q    <= 1'b1;
      a_b_q      <= 1'b0;
      dac_d_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      btn_prev_q <= btn_prev_d;
      csn_q      <= csn_d;
      wrn_q      <= wrn_d;
      ldacn_q    <= ldacn_d;
      a_b_q      <= a_b_d;
      dac_d_q    <= dac_d_d;
    end
  end

  assign dac_csn   = csn_q;
  assign dac_wrn   = wrn_q;
  assign dac_ldacn = ldacn_q;
  assign dac_a_b   = a_b_q;
  assign dac_d     = dac_d_q;
  assign led_out   = value_q;

endmodule

// File: tb/tb_dac_ctrl.sv
// Directed bench for dac_ctrl: strobe timing, button stepping table, snapshot and reset corners.
module tb_dac_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn;
  logic       add_sel;
  logic       dac_csn;
  logic       dac_ldacn;
  logic       dac_wrn;
  logic       dac_a_b;
  logic [7:0] dac_d;
  logic [7:0] led_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dac_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .add_sel   (add_sel),
    .dac_csn   (dac_csn),
    .dac_ldacn (dac_ldacn),
    .dac_wrn   (dac_wrn),
    .dac_a_b   (dac_a_b),
    .dac_d     (dac_d),
    .led_out   (led_out)
  );

  typedef struct {
    logic [5:0] btn;
    int         hold;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic press(input logic [5:0] b);
    btn = b;
    step();
    btn = 6'd0;
    step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Expected {csn, wrn, ldacn} for a cycle n cycles after the last reset edge.
  function automatic logic [2:0] strobe_exp(input int n);
    int p;
    p = n % 15;
    if (p < 10) return 3'b111;
    if (p < 12) return 3'b001;
    if (p == 12) return 3'b011;
    return 3'b110;
  endfunction

  initial begin
    int waited;
    logic [7:0] sat_exp;

    vecs[0]  = '{6'b100000, 300, 8'd1};
    vecs[1]  = '{6'b010000, 300, 8'd0};
    vecs[2]  = '{6'b001000, 300, 8'd2};
    vecs[3]  = '{6'b000100, 300, 8'd0};
    vecs[4]  = '{6'b000010, 300, 8'd8};
    vecs[5]  = '{6'b000001, 300, 8'd0};
    vecs[6]  = '{6'b100010, 4, 8'd1};
    vecs[7]  = '{6'b011111, 4, 8'd0};
`ifdef DAC_CTRL_SATURATE_EN
    vecs[8]  = '{6'b010000, 4, 8'd0};
    vecs[9]  = '{6'b100000, 4, 8'd1};
    vecs[10] = '{6'b000100, 4, 8'd0};
    vecs[11] = '{6'b001000, 4, 8'd2};
    sat_exp  = 8'd255;
`else
    vecs[8]  = '{6'b010000, 4, 8'd255};
    vecs[9]  = '{6'b100000, 4, 8'd0};
    vecs[10] = '{6'b000100, 4, 8'd254};
    vecs[11] = '{6'b001000, 4, 8'd0};
    sat_exp  = 8'd2;
`endif

    rst     = 1'b1;
    btn     = 6'd0;
    add_sel = 1'b0;
    step();
    step();
    check("rst_csn", dac_csn, 1);
    check("rst_wrn", dac_wrn, 1);
    check("rst_ldacn", dac_ldacn, 1);
    check("rst_a_b", dac_a_b, 0);
    check("rst_dac_d", dac_d, 0);
    check("rst_led", led_out, 0);

    rst = 1'b0;
    for (int n = 0; n < 45; n++) begin
      if (n > 0) step();
      check($sformatf("strobe_n%0d", n), {dac_csn, dac_wrn, dac_ldacn}, strobe_exp(n));
    end
    check("idle_dac_d", dac_d, 0);

    for (int i = 0; i < 12; i++) begin
      btn = vecs[i].btn;
      step();
      check($sformatf("vec%0d_first", i), led_out, vecs[i].exp_led);
      repeat (vecs[i].hold - 1) step();
      check($sformatf("vec%0d_held", i), led_out, vecs[i].exp_led);
      btn = 6'd0;
      step();
    end

    waited = 0;
    while (dac_d !== vecs[11].exp_led && waited < 20) begin
      step();
      waited++;
    end
    check("dac_d_follows", dac_d, vecs[11].exp_led);

    // Snapshot stability: value and add_sel changes mid-write wait for the next DELAY exit.
    pulse_reset();
    btn = 6'b100000;
    step();
    btn = 6'd0;
    repeat (8) step();
    check("snap_before", dac_d, 0);
    step();
    check("snap_taken", dac_d, 1);
    check("snap_wrn_low", {dac_csn, dac_wrn}, 2'b00);
    add_sel = 1'b1;
    step();
    check("a_b_hold_setwrn", dac_a_b, 0);
    step();
    check("updata_strobes", {dac_csn, dac_wrn, dac_ldacn}, 3'b011);
    btn = 6'b100000;
    step();
    btn = 6'd0;
    check("led_mid_write", led_out, 2);
    check("dac_d_hold_load", dac_d, 1);
    repeat (11) step();
    check("dac_d_hold_delay", dac_d, 1);
    check("a_b_hold_delay", dac_a_b, 0);
    step();
    check("dac_d_next_snap", dac_d, 2);
    check("a_b_next_snap", dac_a_b, 1);

    // Reset during LOAD with a button held through release.
    repeat (3) step();
    check("in_load", dac_ldacn, 0);
    rst = 1'b1;
    btn = 6'b001000;
    step();
    check("abort_ldacn", dac_ldacn, 1);
    check("abort_led", led_out, 0);
    check("abort_dac_d", dac_d, 0);
    check("abort_a_b", dac_a_b, 0);
    rst = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
      if (waited == 1) check("held_through_rst", led_out, 2);
    end while (dac_wrn !== 1'b0 && waited < 50);
    check("first_wrn_delay", waited, 10);
    check("held_no_repeat", led_out, 2);
    btn = 6'd0;
    add_sel = 1'b0;

    // Approach the top of the range: 31 x (+8) = 248, +2 = 250, then +8.
    pulse_reset();
    repeat (31) press(6'b000010);
    check("reach_248", led_out, 248);
    press(6'b001000);
    check("reach_250", led_out, 250);
    press(6'b000010);
    check("top_plus8", led_out, sat_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_ctrl.md
DAC_CTRL -- requirements
Module: dac_ctrl

Interface
REQ-001 Parameter DELAY_CYCLES, default 10: idle cycles between DAC write cycles; legal range 1..255.
REQ-002 Parameter PULSE_CYCLES, default 2: width in cycles of the dac_wrn and dac_ldacn low pulses; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn  input  6  push-buttons, active-high, level inputs, already synchronous to clk.
REQ-006 add_sel  input  1  DAC channel select: 0 = channel A, 1 = channel B.
REQ-007 dac_csn  output  1  DAC chip select, active-low.
REQ-008 dac_ldacn  output  1  DAC load strobe, active-low.
REQ-009 dac_wrn  output  1  DAC write strobe, active-low.
REQ-010 dac_a_b  output  1  DAC channel address.
REQ-011 dac_d  output  8  DAC data bus.
REQ-012 led_out  output  8  current 8-bit value register, unsigned.

Function
REQ-013 Edge detection: a previous-sample register btn_q[5:0] is kept; event[i] = btn[i] & ~btn_q[i]; btn_q <= btn every cycle.
- Consequence: exactly one event per press, however long the button is held.
REQ-014 Step per button: btn[5] +1, btn[4] -1, btn[3] +2, btn[2] -2, btn[1] +8, btn[0] -8.
REQ-015 Simultaneous events: only the highest-index event bit is applied in that cycle; all others are discarded.
REQ-016 Value register update: on the same rising edge where the event is detected; arithmetic is 8-bit modulo-256 unless REQ-027 applies.
REQ-017 led_out shall equal the value register directly (registered output, no extra delay).
REQ-018 Write FSM states: DELAY, SET_WRN, UP_DATA, LOAD; sequence DELAY -> SET_WRN -> UP_DATA -> LOAD -> DELAY, running continuously.
REQ-019 DELAY: lasts DELAY_CYCLES cycles; dac_csn = 1, dac_wrn = 1, dac_ldacn = 1.
- On exit, dac_d <= value register and dac_a_b <= add_sel (snapshot).
REQ-020 SET_WRN: lasts PULSE_CYCLES cycles; dac_csn = 0, dac_wrn = 0, dac_ldacn = 1.
REQ-021 UP_DATA: lasts 1 cycle; dac_csn = 0, dac_wrn = 1 (rising edge of wrn latches data), dac_ldacn = 1.
REQ-022 LOAD: lasts PULSE_CYCLES cycles; dac_csn = 1, dac_wrn = 1, dac_ldacn = 0.
REQ-023 dac_d and dac_a_b shall be held stable from the snapshot until the next snapshot.
- Value or add_sel changes mid-cycle are picked up at the next DELAY exit only.
REQ-024 All outputs are registered; no output is a combinational function of the inputs.

Reset
REQ-025 While rst = 1 at a rising edge, the following are cleared:
- state <= DELAY; cycle counter <= 0; value <= 0; btn_q <= 0.
- Outputs: dac_csn = 1, dac_wrn = 1, dac_ldacn = 1, dac_a_b = 0, dac_d = 0, led_out = 0.
REQ-026 Reset asserted mid-write aborts the cycle on that edge with the REQ-025 values; after release the FSM restarts with a full DELAY period.
- A button held through reset release produces one event on the first cycle after release.

Configuration
REQ-027 Macro DAC_CTRL_SATURATE_EN.
- Defined: value arithmetic saturates at 0 and 255 (e.g. 250 + 8 = 255, 1 - 2 = 0).
- Undefined: modulo-256 wrap (250 + 8 = 2, 1 - 2 = 255).

Verification
REQ-028 Pulse rst = 1 for one cycle, then btn = 0, add_sel = 0 -> led_out = 0, dac_d = 0.
- Strobes cycle: csn/wrn low for 2 cycles, then 1 cycle csn low with wrn high, then ldacn low for 2 cycles, every 15 cycles.
REQ-029 Hold each button 300 cycles in the order btn[5], btn[4], btn[3], btn[2], btn[1], btn[0] -> led_out sequence 1, 0, 2, 0, 8, 0.
- Each step occurs once, on the first high cycle; dac_d follows on the next write cycle.
REQ-030 From value 0, press btn[4] -> led_out = 255 without macro, 0 with DAC_CTRL_SATURATE_EN.
- Press btn[1] at value 250 -> led_out = 2 without macro, 255 with.
REQ-031 btn = 6'b100010 rising in the same cycle from value 0 -> led_out = 1 (btn[5] wins, btn[1] ignored).
REQ-032 Set add_sel = 1 during SET_WRN -> dac_a_b stays 0 for that cycle and becomes 1 at the next DELAY exit.
- Change value during UP_DATA -> dac_d unchanged until the next snapshot.
REQ-033 Assert rst during LOAD -> next edge: dac_ldacn = 1, led_out = 0; the first dac_wrn low occurs DELAY_CYCLES cycles after release.
